// File: rtl/mult_transaction_checker_if.sv
// Observation bundle for the shift-add multiplier: the multiplier (master) drives every signal
// and the checker (slave) only samples them.
interface mult_transaction_checker_if #(
  parameter int W = 8
);
  // start is accepted when ready is high in the same cycle; a start while ready is low is a
  // NOT_READY event. done qualifies product for exactly the cycles it is high.
  logic             dut_reset_n;
  logic             start;
  logic [W-1:0]     multiplicand;
  logic [W-1:0]     multiplier;
  logic             ready;
  logic             done;
  logic [2*W-1:0]   product;
  logic             dut_in_add;
  logic             dut_in_shift;

  modport master (
    output dut_reset_n, start, multiplicand, multiplier, ready, done, product,
           dut_in_add, dut_in_shift
  );

  modport slave (
    input dut_reset_n, start, multiplicand, multiplier, ready, done, product,
          dut_in_add, dut_in_shift
  );
endinterface

// File: rtl/mult_transaction_checker.sv
// Passive monitor/scoreboard for the shift-add multiplier: product checking, operand-pair coverage,
// student-vs-checker error agreement counters and a run timeout.
module mult_transaction_checker #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  mult_transaction_checker_if.slave         bus,
  input  logic                              stu_bp,
  input  logic                              stu_nr,
  output logic                              init_busy,
  output logic                              bp_err,
  output logic                              nr_err,
  output logic [2*W:0]                      cover_count,
  output logic                              cover_reset_add,
  output logic                              cover_reset_shift,
  output logic                              cover_start_add,
  output logic                              cover_start_shift,
  output logic [CNT_W-1:0]                  bp_false_pos,
  output logic [CNT_W-1:0]                  bp_false_neg,
  output logic [CNT_W-1:0]                  nr_false_pos,
  output logic [CNT_W-1:0]                  nr_false_neg,
  output logic                              timeout
);
  localparam int AW    = 2 * W;
  localparam int DEPTH = 1 << AW;
  localparam int LIMIT = 100 * DEPTH;
  localparam int TW    = $clog2(LIMIT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(LIMIT - 1);
  localparam logic [TW-1:0]    TMO_ONE  = TW'(1);
  localparam logic [AW:0]      CC_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0]    ADDR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN} state_t;
  state_t state, state_next;

  logic [AW-1:0]   clr_addr;
  logic            run;
  logic            pend_valid;
  logic [W-1:0]    pend_a, pend_b;
  logic [AW-1:0]   exp_prod;
  logic            done_eval, prod_ok, cov_hit;
  logic            cov_mem [0:DEPTH-1];
  logic            mem_we, mem_wd;
  logic [AW-1:0]   mem_addr;
  logic [TW-1:0]   tmo_cnt;
  logic [1:0]      chk_now, stu_now;
  logic [3:0]      chk_h [2];
  logic [3:0]      stu_h [2];
  logic [CNT_W-1:0] fp [2];
  logic [CNT_W-1:0] fn [2];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_CLEAR;
      S_CLEAR: if (clr_addr == {AW{1'b1}}) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  assign init_busy = (state == S_CLEAR);
  assign run       = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst)            clr_addr <= '0;
    else if (init_busy) clr_addr <= clr_addr + ADDR_ONE;
  end

  assign exp_prod  = {{W{1'b0}}, pend_a} * {{W{1'b0}}, pend_b};
  assign done_eval = run && bus.dut_reset_n && bus.done && pend_valid;
  assign prod_ok   = (bus.product == exp_prod);
  assign cov_hit   = cov_mem[{pend_a, pend_b}];

  // The bitmap is a plain RAM: the sweep clears it, so it needs no reset of its own.
  assign mem_we   = init_busy || (done_eval && prod_ok);
  assign mem_addr = init_busy ? clr_addr : {pend_a, pend_b};
  assign mem_wd   = !init_busy;

  always_ff @(posedge clk) begin
    if (mem_we) cov_mem[mem_addr] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid        <= 1'b0;
      pend_a            <= '0;
      pend_b            <= '0;
      bp_err            <= 1'b0;
      nr_err            <= 1'b0;
      cover_count       <= '0;
      cover_reset_add   <= 1'b0;
      cover_reset_shift <= 1'b0;
      cover_start_add   <= 1'b0;
      cover_start_shift <= 1'b0;
    end else begin
      bp_err <= 1'b0;
      nr_err <= 1'b0;
      if (run) begin
        if (!bus.dut_reset_n) begin
          pend_valid <= 1'b0;
          if (bus.dut_in_add)   cover_reset_add   <= 1'b1;
          if (bus.dut_in_shift) cover_reset_shift <= 1'b1;
        end else begin
          // done is judged against the old pair before a same-cycle start overwrites it.
          if (done_eval) begin
            pend_valid <= 1'b0;
            if (!prod_ok)     bp_err      <= 1'b1;
            else if (!cov_hit) cover_count <= cover_count + CC_ONE;
          end
          if (bus.start) begin
            if (bus.ready) begin
              pend_a     <= bus.multiplicand;
              pend_b     <= bus.multiplier;
              pend_valid <= 1'b1;
            end else begin
              nr_err <= 1'b1;
              if (bus.dut_in_add)   cover_start_add   <= 1'b1;
              if (bus.dut_in_shift) cover_start_shift <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Channel 0 is BAD_PRODUCT, channel 1 is NOT_READY. History bit 1 is the event two cycles old,
  // judged against ages 0..4 of the opposite stream.
  assign chk_now = {nr_err, bp_err};
  assign stu_now = run ? {stu_nr, stu_bp} : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < 2; ch++) begin
        chk_h[ch] <= '0;
        stu_h[ch] <= '0;
        fp[ch]    <= '0;
        fn[ch]    <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        chk_h[ch] <= {chk_h[ch][2:0], chk_now[ch]};
        stu_h[ch] <= {stu_h[ch][2:0], stu_now[ch]};
        if (stu_h[ch][1] && !(|{chk_h[ch], chk_now[ch]}) && (fp[ch] != {CNT_W{1'b1}}))
          fp[ch] <= fp[ch] + CNT_ONE;
        if (chk_h[ch][1] && !(|{stu_h[ch], stu_now[ch]}) && (fn[ch] != {CNT_W{1'b1}}))
          fn[ch] <= fn[ch] + CNT_ONE;
      end
    end
  end

  assign bp_false_pos = fp[0];
  assign bp_false_neg = fn[0];
  assign nr_false_pos = fp[1];
  assign nr_false_neg = fn[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else if (run && !timeout) begin
      tmo_cnt <= tmo_cnt + TMO_ONE;
      if (tmo_cnt == TMO_LAST) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mult_transaction_checker.sv
// Bench for mult_transaction_checker: a W=4 instance for the monitor/agreement scenarios and an
// idle W=2 instance for clear-sweep length and timeout timing.
module tb_mult_transaction_checker;
  localparam int W     = 4;
  localparam int W2    = 2;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_transaction_checker_if #(.W(W))  bus ();
  mult_transaction_checker_if #(.W(W2)) bus2 ();

  logic stu_bp, stu_nr;
  logic init_busy, bp_err, nr_err, timeout;
  logic [2*W:0] cover_count;
  logic cover_reset_add, cover_reset_shift, cover_start_add, cover_start_shift;
  logic [CNT_W-1:0] bp_false_pos, bp_false_neg, nr_false_pos, nr_false_neg;

  logic init_busy2, bp_err2, nr_err2, timeout2;
  logic [2*W2:0] cover_count2;
  logic cra2, crs2, csa2, css2;
  logic [CNT_W-1:0] bfp2, bfn2, nfp2, nfn2;

  mult_transaction_checker #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stu_bp(stu_bp), .stu_nr(stu_nr),
    .init_busy(init_busy), .bp_err(bp_err), .nr_err(nr_err), .cover_count(cover_count),
    .cover_reset_add(cover_reset_add), .cover_reset_shift(cover_reset_shift),
    .cover_start_add(cover_start_add), .cover_start_shift(cover_start_shift),
    .bp_false_pos(bp_false_pos), .bp_false_neg(bp_false_neg),
    .nr_false_pos(nr_false_pos), .nr_false_neg(nr_false_neg), .timeout(timeout)
  );

  mult_transaction_checker #(.W(W2), .CNT_W(CNT_W)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .stu_bp(1'b0), .stu_nr(1'b0),
    .init_busy(init_busy2), .bp_err(bp_err2), .nr_err(nr_err2), .cover_count(cover_count2),
    .cover_reset_add(cra2), .cover_reset_shift(crs2),
    .cover_start_add(csa2), .cover_start_shift(css2),
    .bp_false_pos(bfp2), .bp_false_neg(bfn2),
    .nr_false_pos(nfp2), .nr_false_neg(nfn2), .timeout(timeout2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected strobes: {cycle seen at negedge, nr_err, bp_err}.
  logic [33:0] exp_q[$];
  logic [33:0] mon_got, mon_exp;
  int t2_seen = -1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bp_err || nr_err)) begin
      mon_got = {cyc[31:0], nr_err, bp_err};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got cycle %0d nr/bp %b expected none", cyc, mon_got[1:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got != mon_exp) begin
          n_fail++;
          $display("FAIL strobe: got cycle %0d nr/bp %b expected cycle %0d nr/bp %b",
                   mon_got[33:2], mon_got[1:0], mon_exp[33:2], mon_exp[1:0]);
        end
      end
    end
    if (timeout2 && t2_seen < 0) t2_seen = cyc;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_strobe(input logic [1:0] code);
    logic [31:0] c;
    c = cyc + 1;
    exp_q.push_back({c, code});
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic rdy, input logic add, input logic shift);
    bus.start = 1'b1; bus.ready = rdy; bus.multiplicand = a; bus.multiplier = b;
    bus.dut_in_add = add; bus.dut_in_shift = shift;
    if (!rdy) expect_strobe(2'b10);
    tick();
    bus.start = 1'b0; bus.ready = 1'b1; bus.dut_in_add = 1'b0; bus.dut_in_shift = 1'b0;
  endtask

  task automatic do_done(input logic [2*W-1:0] p, input logic bad);
    bus.done = 1'b1; bus.product = p;
    if (bad) expect_strobe(2'b01);
    tick();
    bus.done = 1'b0;
  endtask

  task automatic do_both(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
    bus.start = 1'b1; bus.multiplicand = a; bus.multiplier = b;
    bus.done = 1'b1; bus.product = p;
    tick();
    bus.start = 1'b0; bus.done = 1'b0;
  endtask

  task automatic dut_reset(input logic add, input logic shift);
    bus.dut_reset_n = 1'b0; bus.dut_in_add = add; bus.dut_in_shift = shift;
    tick();
    bus.dut_reset_n = 1'b1; bus.dut_in_add = 1'b0; bus.dut_in_shift = 1'b0;
  endtask

  task automatic pulse_stu(input logic is_nr);
    if (is_nr) stu_nr = 1'b1; else stu_bp = 1'b1;
    tick();
    stu_nr = 1'b0; stu_bp = 1'b0;
  endtask

  initial begin
    int busy1, busy2, f2;
    bit seen2;
    stu_bp = 1'b0; stu_nr = 1'b0;
    bus.dut_reset_n = 1'b1; bus.start = 1'b0; bus.ready = 1'b1; bus.done = 1'b0;
    bus.multiplicand = '0; bus.multiplier = '0; bus.product = '0;
    bus.dut_in_add = 1'b0; bus.dut_in_shift = 1'b0;
    bus2.dut_reset_n = 1'b1; bus2.start = 1'b0; bus2.ready = 1'b1; bus2.done = 1'b0;
    bus2.multiplicand = '0; bus2.multiplier = '0; bus2.product = '0;
    bus2.dut_in_add = 1'b0; bus2.dut_in_shift = 1'b0;

    rst = 1'b1;
    idle(3);
    check("rst_init_busy", init_busy, 0);
    check("rst_cover_count", cover_count, 0);
    check("rst_bp_false_pos", bp_false_pos, 0);
    check("rst_timeout", timeout, 0);
    rst = 1'b0;

    // Clear sweep length for both sizes.
    busy1 = 0; busy2 = 0; f2 = -1; seen2 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (init_busy) busy1++;
      if (init_busy2) seen2 = 1'b1;
      else if (seen2 && f2 < 0) f2 = cyc;
      if (init_busy2) busy2++;
    end
    check("init_len_w4", busy1, 256);
    check("init_len_w2", busy2, 16);
    check("init_done_w4", init_busy, 0);

    // 1: good product, repeated pair, new pair.
    do_start(4'd3, 4'd5, 1'b1, 1'b0, 1'b0); idle(2);
    do_done(8'd15, 1'b0); tick();
    check("cov_first_pair", cover_count, 1);
    do_start(4'd3, 4'd5, 1'b1, 1'b0, 1'b0); do_done(8'd15, 1'b0); tick();
    check("cov_repeat_pair", cover_count, 1);
    do_start(4'd2, 4'd6, 1'b1, 1'b0, 1'b0); do_done(8'd12, 1'b0); tick();
    check("cov_second_pair", cover_count, 2);

    // 2: bad product, student strobe 2 cycles after bp_err.
    do_start(4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
    do_done(8'd16, 1'b1);
    idle(2); pulse_stu(1'b0); idle(6);
    check("bp_fp_within2", bp_false_pos, 0);
    check("bp_fn_within2", bp_false_neg, 0);
    check("cov_after_bad", cover_count, 2);

    // 3: student strobe 3 cycles after bp_err.
    do_start(4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
    do_done(8'd16, 1'b1);
    idle(3); pulse_stu(1'b0); idle(6);
    check("bp_fp_off3", bp_false_pos, 1);
    check("bp_fn_off3", bp_false_neg, 1);

    // 4: start while busy in SHIFT, then a lone student NR strobe.
    do_start(4'd1, 4'd1, 1'b0, 1'b0, 1'b1);
    check("cover_start_shift", cover_start_shift, 1);
    check("cover_start_add", cover_start_add, 0);
    idle(5);
    check("nr_fn", nr_false_neg, 1);
    check("nr_fp_zero", nr_false_pos, 0);
    pulse_stu(1'b1); idle(6);
    check("nr_fp_lone", nr_false_pos, 1);
    check("nr_fn_still", nr_false_neg, 1);

    // 5: multiplier reset drops the pending pair.
    do_start(4'd7, 4'd9, 1'b1, 1'b0, 1'b0);
    dut_reset(1'b1, 1'b0);
    check("cover_reset_add", cover_reset_add, 1);
    check("cover_reset_shift_0", cover_reset_shift, 0);
    do_done(8'd63, 1'b0); tick();
    check("cov_after_dut_reset", cover_count, 2);
    dut_reset(1'b0, 1'b1);
    check("cover_reset_shift_1", cover_reset_shift, 1);
    do_start(4'd7, 4'd9, 1'b1, 1'b0, 1'b0); do_done(8'd63, 1'b0); tick();
    check("cov_7x9", cover_count, 3);

    // Same-cycle done/start, stray done, largest operands.
    do_start(4'd4, 4'd4, 1'b1, 1'b0, 1'b0);
    do_both(4'd1, 4'd1, 8'd16); tick();
    check("cov_both_old", cover_count, 4);
    do_done(8'd1, 1'b0); tick();
    check("cov_both_new", cover_count, 5);
    do_done(8'd99, 1'b0); tick();
    check("cov_stray_done", cover_count, 5);
    do_start(4'd15, 4'd15, 1'b1, 1'b0, 1'b0); do_done(8'd225, 1'b0); tick();
    check("cov_max_pair", cover_count, 6);
    idle(6);
    check("bp_fp_final", bp_false_pos, 1);
    check("bp_fn_final", bp_false_neg, 1);

    // 6: timeout of the W=2 instance.
    for (int i = 0; i < 3000 && cyc < f2 + 1620; i++) tick();
    check("timeout_w2_delay", (t2_seen < 0) ? -1 : t2_seen - f2, 1600);
    check("timeout_w2_sticky", timeout2, 1);
    check("timeout_w4_clear", timeout, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
